// File: rtl/usb_rx.sv
// USB full-speed receiver: NRZI bit recovery, unstuffing, SYNC/PID checks, DATA payload into the shared buffer.
// Latency: 2-cycle line sync, mid-bit sampling; store/flush/ready pulses one cycle after the deciding sample.
// Backpressure: none on the line; a store into a full (64) buffer aborts the packet into the error state.
module usb_rx #(
    parameter int CLKS_PER_BIT = 8,
    parameter int BIT_STUFF    = 1
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       dplus_in,
    input  logic       dminus_in,
    input  logic [6:0] buffer_occupancy,
    output logic [2:0] rx_packet,
    output logic       rx_data_ready,
    output logic       rx_transfer_active,
    output logic       rx_error,
    output logic       flush,
    output logic       store_rx_packet_data,
    output logic [7:0] rx_packet_data
);

    localparam int HALF = CLKS_PER_BIT / 2;
    localparam int CW   = $clog2(CLKS_PER_BIT);

    typedef enum logic [3:0] {
        S_IDLE, S_SYNC, S_PID, S_TOKEN, S_DATA, S_EOP, S_EOPJ, S_ERR, S_ERRJ
    } state_t;

    state_t        state, state_nxt;
    logic          dp_meta, dm_meta, dp_s, dm_s, dp_d, dm_d;
    logic [CW-1:0] cnt;
    logic          prev_lvl;
    logic [2:0]    ones, bitcnt;
    logic [7:0]    shreg, hold0, hold1, byte_val;
    logic [1:0]    held, held_nxt, tok_cnt, tok_nxt;
    logic          is_data, is_data_nxt;
    logic [2:0]    pkt_nxt;
    logic          line_edge, jk_start, smp, line_se0, line_j, line_k, nrzi_bit;
    logic          data_smp, se0_smp, stuff_slot, stuff_err, kept, byte_stb, start, buf_full;
    logic          hold_push, store_nxt, flush_nxt, ready_nxt, to_err;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            dp_meta <= 1'b1; dp_s <= 1'b1; dp_d <= 1'b1;
            dm_meta <= 1'b0; dm_s <= 1'b0; dm_d <= 1'b0;
        end else begin
            dp_meta <= dplus_in;  dp_s <= dp_meta; dp_d <= dp_s;
            dm_meta <= dminus_in; dm_s <= dm_meta; dm_d <= dm_s;
        end
    end

    assign line_edge = (dp_s != dp_d) || (dm_s != dm_d);
    assign jk_start  = dp_d & ~dm_d & ~dp_s & dm_s;
    assign line_se0  = ~dp_s & ~dm_s;
    assign line_j    = dp_s & ~dm_s;
    assign line_k    = ~dp_s & dm_s;
    // An edge cycle never samples, so a restart can't double-count a bit.
    assign smp       = (cnt == CW'(HALF)) && !line_edge;
    assign se0_smp   = smp & line_se0;
    assign data_smp  = smp & ~line_se0;
    assign nrzi_bit  = (dp_s == prev_lvl);
    assign stuff_slot = (BIT_STUFF != 0) && (ones == 3'd6);
    assign stuff_err = data_smp & stuff_slot & nrzi_bit;
    assign kept      = data_smp & ~stuff_slot;
    assign byte_stb  = kept && (bitcnt == 3'd7);
    assign byte_val  = {nrzi_bit, shreg[7:1]};
    assign start     = (state == S_IDLE) && jk_start;
    assign buf_full  = (buffer_occupancy >= 7'd64);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cnt      <= '0;
            prev_lvl <= 1'b1;
            ones     <= '0;
            bitcnt   <= '0;
            shreg    <= '0;
        end else begin
            if (line_edge)
                cnt <= CW'(1);
            else if (cnt == CW'(CLKS_PER_BIT - 1))
                cnt <= '0;
            else
                cnt <= cnt + CW'(1);

            if (data_smp)
                prev_lvl <= dp_s;

            if (start) begin
                ones   <= '0;
                bitcnt <= '0;
                shreg  <= '0;
            end else if (data_smp) begin
                if (stuff_slot) begin
                    ones <= '0;
                end else begin
                    if (!nrzi_bit)
                        ones <= '0;
                    else if (ones != 3'd7)
                        ones <= ones + 3'd1;
                    shreg  <= byte_val;
                    bitcnt <= bitcnt + 3'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        pkt_nxt     = rx_packet;
        is_data_nxt = is_data;
        held_nxt    = held;
        tok_nxt     = tok_cnt;
        hold_push   = 1'b0;
        store_nxt   = 1'b0;
        flush_nxt   = 1'b0;
        ready_nxt   = 1'b0;
        to_err      = 1'b0;
        case (state)
            S_IDLE: begin
                if (jk_start) begin
                    state_nxt   = S_SYNC;
                    pkt_nxt     = 3'd0;
                    is_data_nxt = 1'b0;
                    held_nxt    = 2'd0;
                    tok_nxt     = 2'd0;
                end
            end
            S_SYNC: begin
                if (stuff_err || se0_smp)
                    to_err = 1'b1;
                else if (byte_stb) begin
                    if (byte_val == 8'h80) state_nxt = S_PID;
                    else                   to_err    = 1'b1;
                end
            end
            S_PID: begin
                if (stuff_err || se0_smp)
                    to_err = 1'b1;
                else if (byte_stb) begin
                    if (byte_val[3:0] != ~byte_val[7:4]) begin
                        to_err = 1'b1;
                    end else begin
                        case (byte_val[3:0])
                            4'b0001: begin pkt_nxt = 3'd1; state_nxt = S_TOKEN; end
                            4'b1001: begin pkt_nxt = 3'd2; state_nxt = S_TOKEN; end
                            4'b0011: begin pkt_nxt = 3'd3; state_nxt = S_DATA; flush_nxt = 1'b1; is_data_nxt = 1'b1; end
                            4'b1011: begin pkt_nxt = 3'd4; state_nxt = S_DATA; flush_nxt = 1'b1; is_data_nxt = 1'b1; end
                            4'b0010: begin pkt_nxt = 3'd5; state_nxt = S_EOP; end
                            4'b1010: begin pkt_nxt = 3'd6; state_nxt = S_EOP; end
                            default: begin pkt_nxt = 3'd7; state_nxt = S_EOP; end
                        endcase
                    end
                end
            end
            S_TOKEN: begin
                if (stuff_err)
                    to_err = 1'b1;
                else if (se0_smp) begin
                    if (bitcnt == 3'd0 && tok_cnt == 2'd2) state_nxt = S_EOPJ;
                    else                                   to_err    = 1'b1;
                end else if (byte_stb) begin
                    if (tok_cnt == 2'd2) to_err  = 1'b1;
                    else                 tok_nxt = tok_cnt + 2'd1;
                end
            end
            S_DATA: begin
                // The newest two bytes are held back so the CRC16 never reaches the buffer.
                if (stuff_err)
                    to_err = 1'b1;
                else if (se0_smp) begin
                    if (bitcnt == 3'd0 && held == 2'd2) state_nxt = S_EOPJ;
                    else                                to_err    = 1'b1;
                end else if (byte_stb) begin
                    if (held == 2'd2) begin
                        if (buf_full) begin
                            to_err = 1'b1;
                        end else begin
                            store_nxt = 1'b1;
                            hold_push = 1'b1;
                        end
                    end else begin
                        hold_push = 1'b1;
                        held_nxt  = held + 2'd1;
                    end
                end
            end
            S_EOP: begin
                if (stuff_err || byte_stb)
                    to_err = 1'b1;
                else if (se0_smp) begin
                    if (bitcnt == 3'd0) state_nxt = S_EOPJ;
                    else                to_err    = 1'b1;
                end
            end
            S_EOPJ: begin
                if (smp && line_j) begin
                    state_nxt = S_IDLE;
                    ready_nxt = is_data;
                end else if (smp && line_k) begin
                    to_err = 1'b1;
                end
            end
            S_ERR: begin
                if (se0_smp) state_nxt = S_ERRJ;
            end
            S_ERRJ: begin
                if (smp && line_j)      state_nxt = S_IDLE;
                else if (smp && line_k) state_nxt = S_ERR;
            end
            default: state_nxt = S_IDLE;
        endcase
        if (to_err) begin
            state_nxt = se0_smp ? S_ERRJ : S_ERR;
            store_nxt = 1'b0;
            hold_push = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            rx_packet            <= '0;
            rx_data_ready        <= 1'b0;
            rx_transfer_active   <= 1'b0;
            rx_error             <= 1'b0;
            flush                <= 1'b0;
            store_rx_packet_data <= 1'b0;
            rx_packet_data       <= '0;
            is_data              <= 1'b0;
            held                 <= '0;
            tok_cnt              <= '0;
            hold0                <= '0;
            hold1                <= '0;
        end else begin
            rx_packet            <= pkt_nxt;
            is_data              <= is_data_nxt;
            held                 <= held_nxt;
            tok_cnt              <= tok_nxt;
            flush                <= flush_nxt;
            rx_data_ready        <= ready_nxt;
            store_rx_packet_data <= store_nxt;
            rx_transfer_active   <= (state_nxt != S_IDLE);
            if (store_nxt)
                rx_packet_data <= hold1;
            if (hold_push) begin
                hold1 <= hold0;
                hold0 <= byte_val;
            end
            if (start)
                rx_error <= 1'b0;
            else if (to_err)
                rx_error <= 1'b1;
        end
    end

endmodule

// File: tb/tb_usb_rx.sv
// Directed bench for usb_rx: an NRZI/bit-stuffing line driver feeds hand-built packets,
// and a negedge monitor matches every flush/store/ready pulse against a scoreboard queue.
module tb_usb_rx;

    localparam int CLKS = 8;
    localparam logic [1:0] K_STORE = 2'd0, K_FLUSH = 2'd1, K_READY = 2'd2;

    typedef struct packed {
        logic [1:0] kind;
        logic [7:0] dat;
    } exp_t;

    logic       clk = 1'b0;
    logic       n_rst;
    logic       dplus_in, dminus_in;
    logic [6:0] buffer_occupancy;
    logic [2:0] rx_packet;
    logic       rx_data_ready, rx_transfer_active, rx_error, flush, store_rx_packet_data;
    logic [7:0] rx_packet_data;

    exp_t       sb[$];
    logic [7:0] frame[$];
    logic       lvl;
    int         ones;
    int         vectors = 0;
    int         miscompares = 0;

    usb_rx #(.CLKS_PER_BIT(CLKS), .BIT_STUFF(1)) dut (
        .clk                  (clk),
        .n_rst                (n_rst),
        .dplus_in             (dplus_in),
        .dminus_in            (dminus_in),
        .buffer_occupancy     (buffer_occupancy),
        .rx_packet            (rx_packet),
        .rx_data_ready        (rx_data_ready),
        .rx_transfer_active   (rx_transfer_active),
        .rx_error             (rx_error),
        .flush                (flush),
        .store_rx_packet_data (store_rx_packet_data),
        .rx_packet_data       (rx_packet_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_evt(input logic [1:0] kind, input logic [7:0] dat);
        exp_t e;
        e.kind = kind;
        e.dat  = dat;
        sb.push_back(e);
    endtask

    task automatic check_evt(input logic [1:0] kind, input logic [7:0] dat, input string name);
        exp_t e;
        if (sb.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL %s: unexpected pulse (data %02h), nothing expected", name, dat);
        end else begin
            e = sb.pop_front();
            chk(name, {22'd0, kind, dat}, {22'd0, e.kind, e.dat});
        end
    endtask

    always @(negedge clk) begin
        if (n_rst) begin
            if (flush)                check_evt(K_FLUSH, 8'h00, "flush");
            if (store_rx_packet_data) check_evt(K_STORE, rx_packet_data, "store");
            if (rx_data_ready)        check_evt(K_READY, 8'h00, "data_ready");
        end
    end

    task automatic bit_time(input logic dp, input logic dm);
        dplus_in  = dp;
        dminus_in = dm;
        repeat (CLKS) @(negedge clk);
    endtask

    task automatic send_raw(input logic b);
        if (!b) lvl = ~lvl;
        bit_time(lvl, ~lvl);
    endtask

    // bad_stuff puts a 1 where the stuffed 0 belongs.
    task automatic send_byte(input logic [7:0] b, input bit bad_stuff);
        for (int i = 0; i < 8; i++) begin
            send_raw(b[i]);
            ones = b[i] ? ones + 1 : 0;
            if (ones == 6) begin
                send_raw(bad_stuff ? 1'b1 : 1'b0);
                ones = 0;
            end
        end
    endtask

    task automatic send_eop();
        bit_time(1'b0, 1'b0);
        bit_time(1'b0, 1'b0);
        lvl = 1'b1;
        repeat (3) bit_time(1'b1, 1'b0);
    endtask

    task automatic send_frame(input bit bad_stuff);
        lvl  = 1'b1;
        ones = 0;
        send_byte(8'h80, 1'b0);
        chk("active_in_packet", 32'(rx_transfer_active), 32'd1);
        chk("error_cleared_at_start", 32'(rx_error), 32'd0);
        foreach (frame[i]) send_byte(frame[i], bad_stuff);
        send_eop();
    endtask

    task automatic post_check(input string tag, input logic [2:0] pkt, input logic err);
        chk({tag, "_queue_drained"}, 32'(sb.size()), 32'd0);
        chk({tag, "_rx_packet"}, 32'(rx_packet), 32'(pkt));
        chk({tag, "_rx_error"}, 32'(rx_error), 32'(err));
        chk({tag, "_active_low"}, 32'(rx_transfer_active), 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_rx_packet"}, 32'(rx_packet), 32'd0);
        chk({tag, "_pulses"}, {29'd0, flush, store_rx_packet_data, rx_data_ready}, 32'd0);
        chk({tag, "_active_error"}, {30'd0, rx_transfer_active, rx_error}, 32'd0);
        chk({tag, "_data"}, 32'(rx_packet_data), 32'd0);
    endtask

    initial begin
        n_rst = 1'b0;
        dplus_in = 1'b1;
        dminus_in = 1'b0;
        buffer_occupancy = 7'd0;
        lvl = 1'b1;
        ones = 0;
        repeat (5) @(negedge clk);
        #1 check_all_zero("reset");
        @(negedge clk);
        n_rst = 1'b1;
        repeat (20) @(negedge clk);
        chk("idle_active", 32'(rx_transfer_active), 32'd0);

        // Good DATA0: 11 22 33 stored, CRC 4A 5B withheld.
        expect_evt(K_FLUSH, 8'h00);
        expect_evt(K_STORE, 8'h11);
        expect_evt(K_STORE, 8'h22);
        expect_evt(K_STORE, 8'h33);
        expect_evt(K_READY, 8'h00);
        frame = '{8'hC3, 8'h11, 8'h22, 8'h33, 8'h4A, 8'h5B};
        send_frame(1'b0);
        post_check("data0", 3'd3, 1'b0);

        frame = '{8'hD2};
        send_frame(1'b0);
        post_check("ack", 3'd5, 1'b0);

        // Bad PID: C4 fails the complement check.
        frame = '{8'hC4, 8'h11};
        send_frame(1'b0);
        post_check("bad_pid", 3'd0, 1'b1);
        repeat (40) @(negedge clk);
        chk("bad_pid_error_sticky", 32'(rx_error), 32'd1);
        frame = '{8'h5A};
        send_frame(1'b0);
        post_check("nak_after_err", 3'd6, 1'b0);

        // Payload FF: six ones run across PID and payload, so a stuffed 0 is inserted.
        expect_evt(K_FLUSH, 8'h00);
        expect_evt(K_STORE, 8'hFF);
        expect_evt(K_READY, 8'h00);
        frame = '{8'hC3, 8'hFF, 8'h00, 8'h00};
        send_frame(1'b0);
        post_check("stuff_ok", 3'd3, 1'b0);

        expect_evt(K_FLUSH, 8'h00);
        send_frame(1'b1);
        post_check("stuff_bad", 3'd3, 1'b1);

        // Full buffer: the first store attempt (AA) aborts the DATA1 packet.
        buffer_occupancy = 7'd64;
        expect_evt(K_FLUSH, 8'h00);
        frame = '{8'h4B, 8'hAA, 8'hBB, 8'hCC, 8'h12, 8'h34};
        send_frame(1'b0);
        post_check("buf_full", 3'd4, 1'b1);
        buffer_occupancy = 7'd0;

        frame = '{8'hE1, 8'h15, 8'hA0};
        send_frame(1'b0);
        post_check("out_token", 3'd1, 1'b0);

        // Reset after the first stored byte.
        expect_evt(K_FLUSH, 8'h00);
        expect_evt(K_STORE, 8'h11);
        lvl  = 1'b1;
        ones = 0;
        send_byte(8'h80, 1'b0);
        send_byte(8'hC3, 1'b0);
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        send_byte(8'h33, 1'b0);
        repeat (3) @(negedge clk);
        chk("pre_reset_active", 32'(rx_transfer_active), 32'd1);
        n_rst = 1'b0;
        #1 check_all_zero("mid_reset");
        chk("mid_reset_queue", 32'(sb.size()), 32'd0);
        dplus_in  = 1'b1;
        dminus_in = 1'b0;
        repeat (4) @(negedge clk);
        n_rst = 1'b1;
        repeat (20) @(negedge clk);
        frame = '{8'hD2};
        send_frame(1'b0);
        post_check("ack_after_reset", 3'd5, 1'b0);

        repeat (10) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/usb_rx.md
# usb_rx

USB full-speed receiver for the endpoint datapath: the inbound counterpart of the transmitter. It synchronizes `dplus_in`/`dminus_in` and recovers bits from the NRZI line, removing stuffed bits. It validates SYNC and PID, classifies the packet, and writes DATA0/DATA1 payload bytes into the shared data buffer. The CRC16 trailer is withheld from the buffer.

## Interface
- `CLKS_PER_BIT`, 8: clock cycles per USB bit period (≥4, even).
- `BIT_STUFF`, 1: 1 = remove a stuffed zero after six consecutive ones; 0 = no unstuffing (loopback with in-house transmitter).
- `clk` input 1: system clock; all logic on posedge.
- `n_rst` input 1: asynchronous, active-low reset.
- `dplus_in` input 1: raw D+ line (asynchronous).
- `dminus_in` input 1: raw D- line (asynchronous).
- `buffer_occupancy` input 7: data buffer fill level, 0–64.
- `rx_packet` output 3: 0 none, 1 OUT, 2 IN, 3 DATA0, 4 DATA1, 5 ACK, 6 NAK, 7 STALL/other-valid.
- `rx_data_ready` output 1: one-cycle pulse, good DATA packet fully stored.
- `rx_transfer_active` output 1: high while a packet is being received.
- `rx_error` output 1: sticky error flag.
- `flush` output 1: one-cycle pulse, buffer must be cleared.
- `store_rx_packet_data` output 1: one-cycle write strobe to the buffer.
- `rx_packet_data` output 8: byte accompanying the write strobe.

## Operation
- **Input stage:** two-flop synchronizers on both lines. J = (1,0), K = (0,1), SE0 = (0,0).
- **Bit recovery:** a per-bit counter restarts on every synchronized line transition. The line is sampled when the counter reaches `CLKS_PER_BIT/2`, then every `CLKS_PER_BIT` cycles thereafter.
- **NRZI decode:** a sampled level equal to the previous sample = 1; a change = 0.
- **Unstuffing:** with `BIT_STUFF`=1, after six consecutive 1s the next bit must be 0 and is discarded. A 1 in that position is a stuff error.
- **Byte assembly:** bits shift in LSB-first; every eighth kept bit produces an internal byte strobe.
- **FSM states:**
  - IDLE: on the first J→K transition go to SYNC and assert `rx_transfer_active`.
  - SYNC: the first byte must equal 8'h80, else ERR.
  - PID: requires PID[3:0] == ~PID[7:4], else ERR. Sets `rx_packet` from the PID.
    - OUT/IN go to TOKEN.
    - DATA0/DATA1 pulse `flush` and go to DATA.
    - Handshakes go to EOP.
  - TOKEN: discard the 2 address/ENDP/CRC5 bytes; the next item must be EOP.
  - DATA: uses a two-byte hold pipeline. On each byte strobe, if two older bytes are held, the oldest is written (`store_rx_packet_data`=1, `rx_packet_data`=oldest). EOP mid-byte or fewer than 2 bytes held at EOP → ERR.
  - EOP: SE0 for ≥1 sampled bit, then J, returns to IDLE. A DATA packet pulses `rx_data_ready`; the two held bytes (CRC16) are dropped.
  - ERR: assert `rx_error`, stop storing, wait for SE0 then J, then IDLE.
- **Other errors (all go to ERR):** stuff error; SE0 outside a byte boundary; a store when `buffer_occupancy`==64 (the byte is not written).
- `rx_error` clears only on the next J→K packet start.
- `rx_packet` holds its value until the next packet start, then resets to 0.

## Timing
- **Reset:** all outputs 0, FSM IDLE, previous-level register = J.
- **Input latency:** 2 cycles.
- **First sample:** `CLKS_PER_BIT/2` cycles after the synchronized transition.
- **Byte strobe:** on the cycle the eighth kept bit is sampled.
- **Per-byte pulses:**
  - `store_rx_packet_data` is registered: 1 cycle after the byte strobe.
  - `rx_packet_data` is valid in the same cycle as `store_rx_packet_data`.
- **Packet-level pulses:**
  - `flush` is asserted 1 cycle after the PID byte strobe.
  - `rx_data_ready` is asserted 1 cycle after J is sampled following SE0.
  - `rx_transfer_active` falls on that same cycle.
- **Simultaneous events:** packet start while in ERR is ignored until the SE0→J sequence completes. An asynchronous `n_rst` mid-packet returns to IDLE with no pulses.
- **Minimum spacing:** `store_rx_packet_data` pulses are at least 8×`CLKS_PER_BIT` cycles apart.

## Test plan
- **Good DATA0:** SYNC 80, PID C3, payload 11 22 33, CRC 4A 5B, EOP. Required:
  - `flush` once.
  - Stores 11, 22, 33 in order.
  - `rx_packet`=3, `rx_data_ready` pulse, `rx_error`=0.
- **ACK:** PID D2 followed by EOP. Required: `rx_packet`=5, no stores, no `flush`, no `rx_data_ready`.
- **Bad PID:** PID C4. Required: `rx_error`=1, no stores; `rx_error` remains 1 until the next J→K packet start.
- **Stuffing:** payload FF with `BIT_STUFF`=1, stuffed 0 inserted. Required: byte FF stored. Same stream with the stuffed bit forced to 1 → `rx_error`.
- **Buffer full:** `buffer_occupancy`=64 during a 3-byte DATA1 payload. Required: `rx_error`=1, no store strobe.
- **Reset mid-payload:** drop `n_rst` after 1 stored byte. Required: all outputs 0 immediately; the next good ACK decodes correctly.
